// File: rtl/branch_resolve_update.sv
// branch_resolve_update
//   EX-stage branch resolution. Checks each resolved branch against the next
//   PC predicted at fetch. On a mispredict it raises a one-cycle fetch
//   redirect followed by a timed wrong-path flush. It also maintains the
//   global history register. Taken branches are queued to the BTB write port,
//   which uses a valid/ready handshake.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   ex_*              resolved branch from EX (valid, pc, taken, target, pred_pc)
//   ex_stall          combinational: branch not accepted, EX must hold
//   redirect_valid/pc one-cycle fetch redirect and the correct next PC
//   flush             squash younger instructions (redirect + flush window)
//   ghr               global history register
//   upd_*             BTB update head-of-queue (valid/ready + payload)
//   stat_branches/
//   stat_mispred      only with BRU_STATS_EN defined: accepted / mispredicted
//                     branch counters
//
// Build option: define BRU_STATS_EN to add the statistics counters.

module branch_resolve_update #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned GHR_W     = 8,
    parameter int unsigned TAG_LSB   = 12,
    parameter int unsigned QDEPTH    = 4,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid,
    input  logic [XLEN-1:0]         ex_pc,
    input  logic                    ex_taken,
    input  logic [XLEN-1:0]         ex_target,
    input  logic [XLEN-1:0]         ex_pred_pc,
    output logic                    ex_stall,
    output logic                    redirect_valid,
    output logic [XLEN-1:0]         redirect_pc,
    output logic                    flush,
    output logic [GHR_W-1:0]        ghr,
    output logic                    upd_valid,
    input  logic                    upd_ready,
    output logic [XLEN-1:0]         upd_pc,
    output logic [XLEN-TAG_LSB-1:0] upd_tag,
    output logic [XLEN-1:0]         upd_target,
    output logic [GHR_W-1:0]        upd_old_pattern,
    output logic [GHR_W-1:0]        upd_new_pattern
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]             stat_branches,
    output logic [31:0]             stat_mispred
`endif
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  target;
        logic [GHR_W-1:0] old_pat;
        logic [GHR_W-1:0] new_pat;
    } upd_entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [FC_W-1:0]  flush_cnt;

    upd_entry_t       fifo_mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    logic [XLEN-1:0]  actual_next_c;
    logic             mispred_c;
    logic             in_idle_c;
    logic             fifo_full_c;
    logic             accept_c;
    logic             push_c;
    logic             pop_c;
    logic [GHR_W-1:0] ghr_shift_c;
    upd_entry_t       head_c;

    // Branch resolution and acceptance
    always_comb begin
        actual_next_c = ex_taken ? ex_target : XLEN'(ex_pc + XLEN'(4));
        mispred_c     = (actual_next_c != ex_pred_pc);
        in_idle_c     = (state == IDLE);
        fifo_full_c   = (count == CNT_W'(QDEPTH));
        // Wrong-path branches outside IDLE are dropped, never stalled.
        ex_stall      = ex_valid & ex_taken & fifo_full_c & in_idle_c;
        accept_c      = ex_valid & ~ex_stall & in_idle_c;
        push_c        = accept_c & ex_taken;
        pop_c         = upd_valid & upd_ready;
        ghr_shift_c   = {ghr[GHR_W-2:0], ex_taken};
        count_nxt     = CNT_W'(count + CNT_W'(push_c) - CNT_W'(pop_c));
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_c && mispred_c) begin
                    state_nxt = REDIRECT;
                end
            end
            REDIRECT: begin
                state_nxt = (FLUSH_CYC == 1) ? IDLE : FLUSH;
            end
            FLUSH: begin
                if (flush_cnt == FC_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register and registered redirect/flush outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            flush_cnt      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
        end else begin
            state          <= state_nxt;
            redirect_valid <= (state_nxt == REDIRECT);
            flush          <= (state_nxt != IDLE);
            if (accept_c && mispred_c) begin
                redirect_pc <= actual_next_c;
            end
            // Loaded while redirecting; counts the remaining flush cycles.
            if (state == REDIRECT) begin
                flush_cnt <= FC_W'(FLUSH_CYC - 1);
            end else if (state == FLUSH) begin
                flush_cnt <= FC_W'(flush_cnt - FC_W'(1));
            end
        end
    end

    // Global history
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (accept_c) begin
            ghr <= ghr_shift_c;
        end
    end

    // BTB update queue; the count separates full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            upd_valid <= 1'b0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push_c) begin
                fifo_mem[wr_ptr] <= '{pc: ex_pc, target: ex_target,
                                      old_pat: ghr, new_pat: ghr_shift_c};
                wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
            end
            if (pop_c) begin
                rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
            end
            count     <= count_nxt;
            upd_valid <= (count_nxt != '0);
        end
    end

    // Head of queue drives the update port; held while ready is low
    always_comb begin
        head_c          = fifo_mem[rd_ptr];
        upd_pc          = head_c.pc;
        upd_tag         = head_c.pc[XLEN-1:TAG_LSB];
        upd_target      = head_c.target;
        upd_old_pattern = head_c.old_pat;
        upd_new_pattern = head_c.new_pat;
    end

`ifdef BRU_STATS_EN
    // Accepted-branch and mispredict counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (accept_c) begin
            stat_branches <= stat_branches + 32'd1;
            if (mispred_c) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_update.sv
// Testbench for branch_resolve_update: table-driven resolution vectors,
// hand-written multi-cycle sequences, and a scoreboard on the BTB update port.
module tb_branch_resolve_update;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] ex_pred_pc;
    logic        ex_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [7:0]  ghr;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [19:0] upd_tag;
    logic [31:0] upd_target;
    logic [7:0]  upd_old_pattern;
    logic [7:0]  upd_new_pattern;
`ifdef BRU_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    branch_resolve_update dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid        (ex_valid),
        .ex_pc           (ex_pc),
        .ex_taken        (ex_taken),
        .ex_target       (ex_target),
        .ex_pred_pc      (ex_pred_pc),
        .ex_stall        (ex_stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .flush           (flush),
        .ghr             (ghr),
        .upd_valid       (upd_valid),
        .upd_ready       (upd_ready),
        .upd_pc          (upd_pc),
        .upd_tag         (upd_tag),
        .upd_target      (upd_target),
        .upd_old_pattern (upd_old_pattern),
        .upd_new_pattern (upd_new_pattern)
`ifdef BRU_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispred    (stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic [31:0] pred;
        logic        exp_mis;
        logic [31:0] exp_rpc;
        logic [7:0]  exp_ghr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic [7:0]  old_p;
        logic [7:0]  new_p;
    } upd_t;

    vec_t        vecs [6];
    upd_t        sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  m_ghr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic tk,
                         input logic [31:0] tg, input logic [31:0] pr);
        ex_valid   = 1'b1;
        ex_pc      = pc;
        ex_taken   = tk;
        ex_target  = tg;
        ex_pred_pc = pr;
    endtask

    task automatic idle_in;
        ex_valid   = 1'b0;
        ex_pc      = '0;
        ex_taken   = 1'b0;
        ex_target  = '0;
        ex_pred_pc = '0;
    endtask

    // Record the expected effect of a branch the bench knows will be accepted
    task automatic expect_accept(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        upd_t e;
        e.pc     = pc;
        e.target = tg;
        e.old_p  = m_ghr;
        m_ghr    = {m_ghr[6:0], tk};
        e.new_p  = m_ghr;
        if (tk) sb.push_back(e);
    endtask

    // Scoreboard: a handshake seen at the negedge completes on the next posedge
    always @(negedge clk) begin
        if (!rst && upd_valid && upd_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL upd_unexpected: got update pc=0x%0h, expected none", upd_pc);
            end else begin
                upd_t e;
                e = sb.pop_front();
                check("upd_pc",     64'(upd_pc),          64'(e.pc));
                check("upd_tag",    64'(upd_tag),         64'(e.pc[31:12]));
                check("upd_target", 64'(upd_target),      64'(e.target));
                check("upd_old",    64'(upd_old_pattern), 64'(e.old_p));
                check("upd_new",    64'(upd_new_pattern), 64'(e.new_p));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        vecs[0] = '{32'h0000_0100, 1'b1, 32'h0000_0200, 32'h0000_0200, 1'b0, 32'h0,          8'h01};
        vecs[1] = '{32'h0000_1000, 1'b0, 32'h0000_0000, 32'h0000_2000, 1'b1, 32'h0000_1004, 8'h02};
        vecs[2] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0,          8'h04};
        vecs[3] = '{32'h0000_3000, 1'b1, 32'h0000_4000, 32'h0000_3004, 1'b1, 32'h0000_4000, 8'h09};
        vecs[4] = '{32'h1234_5678, 1'b0, 32'h0000_0000, 32'h1234_567C, 1'b0, 32'h0,          8'h12};
        vecs[5] = '{32'hABCD_E000, 1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1, 32'h0000_0010, 8'h25};

        rst = 1'b1;
        upd_ready = 1'b1;
        m_ghr = '0;
        idle_in();
        step();
        step();
        @(negedge clk);
        check("rst_redirect_valid", 64'(redirect_valid), 64'(0));
        check("rst_redirect_pc",    64'(redirect_pc),    64'(0));
        check("rst_flush",          64'(flush),          64'(0));
        check("rst_ghr",            64'(ghr),            64'(0));
        check("rst_upd_valid",      64'(upd_valid),      64'(0));
        check("rst_ex_stall",       64'(ex_stall),       64'(0));
        step();
        rst = 1'b0;

        // Table of single resolved branches
        for (int i = 0; i < 6; i++) begin
            step();
            drive(vecs[i].pc, vecs[i].taken, vecs[i].target, vecs[i].pred);
            @(negedge clk);
            check("vec_stall", 64'(ex_stall), 64'(0));
            step();
            idle_in();
            expect_accept(vecs[i].pc, vecs[i].taken, vecs[i].target);
            @(negedge clk);
            check("vec_redirect_valid", 64'(redirect_valid), 64'(vecs[i].exp_mis));
            check("vec_flush_c1",       64'(flush),          64'(vecs[i].exp_mis));
            check("vec_ghr",            64'(ghr),            64'(vecs[i].exp_ghr));
            if (vecs[i].exp_mis) check("vec_redirect_pc", 64'(redirect_pc), 64'(vecs[i].exp_rpc));
            step();
            @(negedge clk);
            check("vec_redirect_pulse", 64'(redirect_valid), 64'(0));
            check("vec_flush_c2",       64'(flush),          64'(vecs[i].exp_mis));
            step();
            @(negedge clk);
            check("vec_flush_c3",       64'(flush),          64'(0));
        end

        // Wrong-path branch held during redirect/flush is dropped
        step();
        drive(32'h0000_1000, 1'b0, 32'h0, 32'h0000_2000);
        step();
        expect_accept(32'h0000_1000, 1'b0, 32'h0);
        drive(32'h0000_5000, 1'b1, 32'h0000_6000, 32'h0000_6000);
        @(negedge clk);
        check("wp_redirect", 64'(redirect_valid), 64'(1));
        check("wp_stall_r",  64'(ex_stall),       64'(0));
        check("wp_ghr_r",    64'(ghr),            64'(m_ghr));
        step();
        @(negedge clk);
        check("wp_flush",    64'(flush),          64'(1));
        check("wp_stall_f",  64'(ex_stall),       64'(0));
        step();
        idle_in();
        @(negedge clk);
        check("wp_ghr_end",  64'(ghr),            64'(m_ghr));
        check("wp_no_enq",   64'(upd_valid),      64'(0));
        check("wp_flush_end",64'(flush),          64'(0));

        // Backpressure: fill the queue, 5th taken branch stalls
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            drive(32'h0000_2000 + 32'(i * 16), 1'b1, 32'h0000_8000 + 32'(i * 256),
                  32'h0000_8000 + 32'(i * 256));
            expect_accept(ex_pc, 1'b1, ex_target);
            @(negedge clk);
            check("bp_fill_stall", 64'(ex_stall), 64'(0));
        end
        step();
        drive(32'h0000_2100, 1'b1, 32'h0000_9000, 32'h0000_9000);
        @(negedge clk);
        check("bp_full_stall", 64'(ex_stall),  64'(1));
        check("bp_upd_valid",  64'(upd_valid), 64'(1));
        check("bp_hold_pc1",   64'(upd_pc),    64'(sb[0].pc));
        step();
        @(negedge clk);
        check("bp_full_stall2",64'(ex_stall),  64'(1));
        check("bp_ghr_held",   64'(ghr),       64'(m_ghr));
        check("bp_hold_pc2",   64'(upd_pc),    64'(sb[0].pc));
        expect_accept(32'h0000_2100, 1'b1, 32'h0000_9000);
        step();
        upd_ready = 1'b1;
        waited = 0;
        @(negedge clk);
        while (ex_stall && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (waited >= 10) begin
            n_fail++;
            $display("FAIL bp_release: got stall for %0d cycles, expected release", waited);
        end
        step();
        idle_in();
        repeat (8) step();
        @(negedge clk);
        check("bp_ghr_after", 64'(ghr),       64'(m_ghr));
        check("bp_drained",   64'(sb.size()), 64'(0));

        // Nine back-to-back push/pop pairs wrap the pointers
        for (int i = 0; i < 9; i++) begin
            step();
            drive(32'h4000_0000 + 32'(i * 4), 1'b1, 32'h4000_1000 + 32'(i * 64),
                  32'h4000_1000 + 32'(i * 64));
            expect_accept(ex_pc, 1'b1, ex_target);
            @(negedge clk);
            check("wrap_stall", 64'(ex_stall), 64'(0));
        end
        step();
        idle_in();
        repeat (3) step();
        @(negedge clk);
        check("wrap_ghr",     64'(ghr),       64'(m_ghr));
        check("wrap_drained", 64'(sb.size()), 64'(0));

        // Reset during a redirect with two updates queued
        upd_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            drive(32'h0000_6000 + 32'(i * 8), 1'b1, 32'h0000_6800, 32'h0000_6800);
            expect_accept(ex_pc, 1'b1, ex_target);
        end
        step();
        drive(32'h0000_7000, 1'b0, 32'h0, 32'h0000_7008);
        step();
        idle_in();
        rst = 1'b1;
        @(negedge clk);
        check("rr_pre_redirect", 64'(redirect_valid), 64'(1));
        check("rr_pre_upd",      64'(upd_valid),      64'(1));
        step();
        rst = 1'b0;
        sb.delete();
        m_ghr = '0;
        @(negedge clk);
        check("rr_flush",     64'(flush),          64'(0));
        check("rr_redirect",  64'(redirect_valid), 64'(0));
        check("rr_upd_valid", 64'(upd_valid),      64'(0));
        check("rr_ghr",       64'(ghr),            64'(0));
        step();
        @(negedge clk);
        check("rr_flush2",    64'(flush),          64'(0));
        upd_ready = 1'b1;
        step();
        drive(32'h0000_0100, 1'b1, 32'h0000_0200, 32'h0000_0200);
        expect_accept(ex_pc, 1'b1, ex_target);
        step();
        idle_in();
        @(negedge clk);
        check("rr_idle_accept_ghr", 64'(ghr), 64'(8'h01));
        repeat (3) step();
        @(negedge clk);
        check("final_drained", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
